mem_block_mover: RTL and testbench
==================================

# mem_block_mover

Bus-initiator block that drives the single-port data-memory interface (MemRead/MemWrite/address/write_data/read_data) from the other side. It performs word-granular block copy or block fill without CPU involvement. It sits beside the pipeline's MEM stage and owns the memory port only while busy; a port mux outside this block arbitrates.

## Interface
- `LEN_W`, 16: width of the word-count operand.
- `clk` input 1: system clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `mode` input 1: 0 = copy (src→dst), 1 = fill (fill_value→dst).
- `src_addr` input 32: byte address of first source word; copy mode only.
- `dst_addr` input 32: byte address of first destination word.
- `len_words` input LEN_W: number of 32-bit words to transfer.
- `fill_value` input 32: data written in fill mode.
- `busy` output 1: high in READ/WRITE states.
- `done` output 1: one-cycle pulse at completion, including error and zero-length requests.
- `error` output 1: pulses with done when the request is rejected.
- `words_left` output LEN_W: remaining words; 0 when idle.
- `MemRead` output 1: memory read enable.
- `MemWrite` output 1: memory write enable (memory commits on negedge of the same cycle).
- `mem_address` output 32: byte address to memory.
- `mem_write_data` output 32: write data to memory.
- `mem_read_data` input 32: combinational read data from memory, valid in the same cycle as MemRead.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start:
  - latch src, dst, len, mode, fill_value.
  - Misaligned request (src[1:0]≠0 in copy mode, or dst[1:0]≠0): go to DONE with error=1, no memory access.
  - len=0: go to DONE, error=0.
  - Otherwise go to READ (copy) or WRITE (fill).
- READ: MemRead=1, mem_address=src_ptr. Capture mem_read_data into data_buf at posedge. src_ptr+=4. Next state WRITE.
- WRITE: MemWrite=1, mem_address=dst_ptr, mem_write_data=data_buf (copy) or fill_value (fill). At posedge: dst_ptr+=4, words_left−=1.
  - words_left reaches 0 → DONE.
  - Otherwise → READ (copy) or WRITE (fill).
- DONE: done=1 (error as latched) for one cycle, then → IDLE.
- start is ignored outside IDLE; operands are not re-sampled.
- Pointer arithmetic is 32-bit and wraps modulo 2^32. No range check against memory size.
- Overlapping regions: strictly ascending word-by-word copy. If dst>src, the overlap is overwritten before it is read; this is accepted, defined behaviour.
- MemRead and MemWrite are never high in the same cycle.
- Outside READ/WRITE: MemRead=0, MemWrite=0, mem_address=0, mem_write_data=0.

## Timing
- Reset (any state, including mid-transfer): next cycle state=IDLE. busy, done, error, MemRead, MemWrite = 0. mem_address, mem_write_data, words_left, data_buf, pointers = 0.
  - A WRITE cycle in which reset is asserted still presents MemWrite=1 combinationally. The negedge write in that cycle completes.
  - No further accesses follow reset.
- start sampled at edge 0:
  - Copy: READ/WRITE occupy cycles 1..2L; done is high in cycle 2L+1.
  - Fill: WRITE occupies cycles 1..L; done is high in cycle L+1.
  - Zero-length or error: done is high in cycle 1.
- Earliest restart: start sampled at the posedge ending the DONE cycle is ignored. start is accepted on the following edge (IDLE).
- mem_read_data is sampled only at the posedge closing a READ cycle.

## Structure
- Shared package `mem_block_mover_pkg`:
  - state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
  - MODE_COPY=1'b0, MODE_FILL=1'b1.
  - WORD_BYTES=4.
- One sub-module: `mem_block_mover_ptr`, the pointer/count datapath (src_ptr, dst_ptr, words_left with load/increment/decrement controls). The FSM and output decode live in the top.

## Test plan
- Copy: preload mem words 0..3 = 0x11,0x22,0x33,0x44. Request src=0x00, dst=0x40, len=4 → words 16..19 = 0x11..0x44; done in cycle 9; busy high in cycles 1..8; MemRead/MemWrite alternate.
- Fill: dst=0x80, len=3, fill=0xDEADBEEF → words 32..34 = 0xDEADBEEF; done in cycle 4; MemRead never asserted.
- Error and zero length:
  - dst=0x42 → done=1 and error=1 in cycle 1, no MemWrite.
  - len=0 → done=1, error=0 in cycle 1.
- Reset mid-copy: src=0, dst=0x40, len=8; assert reset in cycle 5 (READ) → no writes after cycle 4, words 18..23 unchanged, all outputs 0 next cycle.
- Start while busy: pulse start with different operands in cycle 2 of an active copy → ignored; the original transfer completes unchanged.
- Overlap: words 0..3 = 1,2,3,4; copy src=0, dst=4, len=3 → words 1..3 = 1,1,1.

Source files
------------

// File: rtl/mem_block_mover_pkg.sv
// Shared types and constants for the memory block mover.
package mem_block_mover_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_block_mover_if.sv
// Single-port data-memory bus. The mover is the master; the memory (or port mux) is the slave.
interface mem_block_mover_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output MemRead,
        output MemWrite,
        output mem_address,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  mem_address,
        input  mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/mem_block_mover_ptr.sv
// Pointer and word-count datapath: source/destination byte pointers and remaining word count.
module mem_block_mover_ptr
    import mem_block_mover_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [31:0]      src_in,
    input  logic [31:0]      dst_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             step_src,
    input  logic             step_dst,
    output logic [31:0]      src_ptr,
    output logic [31:0]      dst_ptr,
    output logic [LEN_W-1:0] words_left
);

    // Load operands on an accepted request, then advance one word per access; pointers wrap mod 2^32.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            words_left <= '0;
        end else if (load) begin
            src_ptr    <= src_in;
            dst_ptr    <= dst_in;
            words_left <= len_in;
        end else begin
            if (step_src) begin
                src_ptr <= src_ptr + 32'(WORD_BYTES);
            end
            if (step_dst) begin
                dst_ptr    <= dst_ptr + 32'(WORD_BYTES);
                words_left <= words_left - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_block_mover.sv
// Word-granular block copy/fill engine that drives the data-memory port while busy.
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_left,
    mem_block_mover_if.master mem
);

    state_t           state, state_next;
    logic             mode_q;
    logic             error_q;
    logic [31:0]      fill_q;
    logic [31:0]      data_buf;
    logic             load;
    logic             step_src;
    logic             step_dst;
    logic             misaligned;
    logic [LEN_W-1:0] len_load;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;

    assign misaligned = ((mode == MODE_COPY) && (src_addr[1:0] != 2'b00)) ||
                        (dst_addr[1:0] != 2'b00);

    // A rejected request never moves data, so its count is loaded as zero.
    assign len_load = misaligned ? '0 : len_words;

    mem_block_mover_ptr #(.LEN_W(LEN_W)) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .src_in     (src_addr),
        .dst_in     (dst_addr),
        .len_in     (len_load),
        .step_src   (step_src),
        .step_dst   (step_dst),
        .src_ptr    (src_ptr),
        .dst_ptr    (dst_ptr),
        .words_left (words_left)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch request operands on acceptance and capture read data at the close of each READ.
    always_ff @(posedge clk) begin
        // NOTE: data_buf is a single register, not a memory array, so it is cleared with the rest of the state.
        if (reset) begin
            mode_q   <= MODE_COPY;
            error_q  <= 1'b0;
            fill_q   <= '0;
            data_buf <= '0;
        end else begin
            if (load) begin
                mode_q  <= mode;
                error_q <= misaligned;
                fill_q  <= fill_value;
            end
            if (state == READ) begin
                data_buf <= mem.mem_read_data;
            end
        end
    end

    // Next-state and output decode; the bus is driven only in READ/WRITE.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_next         = state;
        load               = 1'b0;
        step_src           = 1'b0;
        step_dst           = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        error              = 1'b0;
        mem.MemRead        = 1'b0;
        mem.MemWrite       = 1'b0;
        mem.mem_address    = '0;
        mem.mem_write_data = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (misaligned || (len_words == '0)) begin
                        state_next = DONE;
                    end else if (mode == MODE_COPY) begin
                        state_next = READ;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            READ: begin
                busy            = 1'b1;
                mem.MemRead     = 1'b1;
                mem.mem_address = src_ptr;
                step_src        = 1'b1;
                state_next      = WRITE;
            end
            WRITE: begin
                busy               = 1'b1;
                mem.MemWrite       = 1'b1;
                mem.mem_address    = dst_ptr;
                mem.mem_write_data = (mode_q == MODE_FILL) ? fill_q : data_buf;
                step_dst           = 1'b1;
                if (words_left == LEN_W'(1)) begin
                    state_next = DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_next = READ;
                end else begin
                    state_next = WRITE;
                end
            end
            DONE: begin
                done       = 1'b1;
                error      = error_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover: a word memory model plus a write scoreboard.
module tb_mem_block_mover;
    import mem_block_mover_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic [31:0]      fill_value = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_left;

    mem_block_mover_if bus ();

    logic [31:0] mem [0:255];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_w;

    int total = 0;
    int bad   = 0;

    int obs_done, obs_busy, obs_rd, obs_wr;
    bit obs_both, obs_err, obs_alt;

    always #5 clk = ~clk;

    mem_block_mover #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_left (words_left),
        .mem        (bus)
    );

    assign bus.mem_read_data = mem[bus.mem_address[9:2]];

    // Memory commits on negedge; every write is checked against the scoreboard.
    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         bus.mem_address, bus.mem_write_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.mem_address, bus.mem_write_data} !== exp_w) begin
                    bad++;
                    $display("FAIL write_sb: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_address, bus.mem_write_data, exp_w.addr, exp_w.data);
                end
            end
            mem[bus.mem_address[9:2]] = bus.mem_write_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle request; returns #1 into cycle 1.
    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input logic [31:0] f);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len_words = l; fill_value = f;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Push the writes an ascending word-by-word copy must produce, using a shadow of the bench memory.
    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int l);
        logic [31:0] shadow [0:255];
        logic [7:0]  si, di;
        shadow = mem;
        for (int i = 0; i < l; i++) begin
            si = s[9:2] + 8'(i);
            di = d[9:2] + 8'(i);
            shadow[di] = shadow[si];
            exp_q.push_back('{addr: d + 32'(4 * i), data: shadow[si]});
        end
    endtask

    // Watch the DUT from cycle 'first' until done, bounded to 200 cycles.
    task automatic observe(input int first);
        int prev;
        prev = 0;
        obs_done = -1; obs_busy = 0; obs_rd = 0; obs_wr = 0;
        obs_both = 0; obs_err = 0; obs_alt = 1;
        for (int c = first; c < first + 200; c++) begin
            if (busy) obs_busy++;
            if (bus.MemRead && bus.MemWrite) obs_both = 1;
            if (bus.MemRead) begin
                obs_rd++;
                if (prev == 1) obs_alt = 0;
                prev = 1;
            end
            if (bus.MemWrite) begin
                obs_wr++;
                if (prev == 2) obs_alt = 0;
                prev = 2;
            end
            if (done) begin
                obs_done = c;
                obs_err  = error;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (obs_done < 0) begin
            bad++;
            $display("FAIL timeout: done not seen within 200 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        total++;
        if ({busy, done, error, bus.MemRead, bus.MemWrite} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {busy, done, error, bus.MemRead, bus.MemWrite});
        end
        total++;
        if ({bus.mem_address, bus.mem_write_data, words_left} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h left=%0d, required all 0",
                     bus.mem_address, bus.mem_write_data, words_left);
        end
        reset = 1'b0;
        idle(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_copy();
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        expect_copy(32'h0, 32'h40, 4);
        issue(MODE_COPY, 32'h0, 32'h40, 16'd4, 32'h0);
        total++;
        if (words_left !== 16'd4) begin
            bad++;
            $display("FAIL copy_words_left: got %0d, required 4", words_left);
        end
        observe(1);
        total++;
        if (obs_done !== 9) begin
            bad++;
            $display("FAIL copy_done_cycle: got %0d, required 9", obs_done);
        end
        total++;
        if (obs_busy !== 8) begin
            bad++;
            $display("FAIL copy_busy_cycles: got %0d, required 8", obs_busy);
        end
        total++;
        if (!obs_alt || obs_both || obs_rd !== 4 || obs_wr !== 4) begin
            bad++;
            $display("FAIL copy_alternate: alt=%0d both=%0d rd=%0d wr=%0d, required 1 0 4 4",
                     obs_alt, obs_both, obs_rd, obs_wr);
        end
        total++;
        if (obs_err !== 1'b0) begin
            bad++;
            $display("FAIL copy_error: got %b, required 0", obs_err);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[16 + i] !== 32'h11 * (i + 1)) begin
                bad++;
                $display("FAIL copy_word%0d: got %h, required %h", 16 + i, mem[16 + i], 32'h11 * (i + 1));
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 32'h80 + 32'(4 * i), data: 32'hDEADBEEF});
        // Source alignment must not matter in fill mode.
        issue(MODE_FILL, 32'h3, 32'h80, 16'd3, 32'hDEADBEEF);
        observe(1);
        total++;
        if (obs_done !== 4 || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL fill_done: cycle=%0d err=%b, required 4 0", obs_done, obs_err);
        end
        total++;
        if (obs_rd !== 0 || obs_wr !== 3) begin
            bad++;
            $display("FAIL fill_access: rd=%0d wr=%0d, required 0 3", obs_rd, obs_wr);
        end
        idle(2);
        for (int i = 32; i < 35; i++) begin
            total++;
            if (mem[i] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL fill_word%0d: got %h, required deadbeef", i, mem[i]);
            end
        end
    endtask

    task automatic test_error();
        issue(MODE_COPY, 32'h0, 32'h42, 16'd2, 32'h0);
        observe(1);
        total++;
        if (obs_done !== 1 || obs_err !== 1'b1 || obs_wr !== 0) begin
            bad++;
            $display("FAIL err_dst: cycle=%0d err=%b wr=%0d, required 1 1 0", obs_done, obs_err, obs_wr);
        end
        idle(1);
        issue(MODE_COPY, 32'h2, 32'h40, 16'd1, 32'h0);
        observe(1);
        total++;
        if (obs_done !== 1 || obs_err !== 1'b1 || obs_rd !== 0) begin
            bad++;
            $display("FAIL err_src: cycle=%0d err=%b rd=%0d, required 1 1 0", obs_done, obs_err, obs_rd);
        end
        idle(1);
    endtask

    task automatic test_zero_len_restart();
        issue(MODE_COPY, 32'h0, 32'h40, 16'd0, 32'h0);
        total++;
        if (done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: done=%b err=%b, required 1 0", done, error);
        end
        // Hold start through the DONE edge (ignored) and the next IDLE edge (accepted).
        exp_q.push_back('{addr: 32'h2C0, data: 32'h5A5A5A5A});
        start = 1'b1; mode = MODE_FILL; dst_addr = 32'h2C0; len_words = 16'd1; fill_value = 32'h5A5A5A5A;
        idle(1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_done_edge: busy=%b, required 0", busy);
        end
        idle(1);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL restart_accept: busy=%b wr=%b, required 1 1", busy, bus.MemWrite);
        end
        observe(3);
        total++;
        if (obs_done !== 4) begin
            bad++;
            $display("FAIL restart_done_cycle: got %0d, required 4", obs_done);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_copy();
        for (int i = 0; i < 8; i++) begin
            mem[i]      = 32'h100 + 32'(i);
            mem[16 + i] = 32'hAAAA0000 + 32'(i);
        end
        exp_q.push_back('{addr: 32'h40, data: 32'h100});
        exp_q.push_back('{addr: 32'h44, data: 32'h101});
        issue(MODE_COPY, 32'h0, 32'h40, 16'd8, 32'h0);
        idle(4);
        total++;
        if (bus.MemRead !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_read: cycle 5 MemRead=%b, required 1", bus.MemRead);
        end
        reset = 1'b1;
        idle(1);
        total++;
        if ({busy, done, error, bus.MemRead, bus.MemWrite} !== 5'b0 ||
            {bus.mem_address, bus.mem_write_data, words_left} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: ctrl=%b addr=%h wdata=%h left=%0d, required all 0",
                     {busy, done, error, bus.MemRead, bus.MemWrite},
                     bus.mem_address, bus.mem_write_data, words_left);
        end
        reset = 1'b0;
        idle(6);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rst_mid_pending: %0d writes missing, required 0", exp_q.size());
            exp_q.delete();
        end
        for (int i = 18; i < 24; i++) begin
            total++;
            if (mem[i] !== 32'hAAAA0000 + 32'(i - 16)) begin
                bad++;
                $display("FAIL rst_mid_word%0d: got %h, required %h", i, mem[i], 32'hAAAA0000 + 32'(i - 16));
            end
        end
    endtask

    task automatic test_start_busy();
        mem[0] = 32'hC0; mem[1] = 32'hC1; mem[2] = 32'hC2; mem[192] = 32'h0;
        expect_copy(32'h0, 32'h200, 3);
        issue(MODE_COPY, 32'h0, 32'h200, 16'd3, 32'h0);
        idle(1);
        start = 1'b1; mode = MODE_FILL; src_addr = 32'h0; dst_addr = 32'h300; len_words = 16'd5;
        fill_value = 32'h0BAD0BAD;
        idle(1);
        start = 1'b0;
        observe(3);
        total++;
        if (obs_done !== 7 || obs_err !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_done: cycle=%0d err=%b, required 7 0", obs_done, obs_err);
        end
        idle(8);
        total++;
        if (exp_q.size() !== 0 || mem[192] !== 32'h0) begin
            bad++;
            $display("FAIL busy_start_effect: pending=%0d word192=%h, required 0 0", exp_q.size(), mem[192]);
            exp_q.delete();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[128 + i] !== 32'hC0 + 32'(i)) begin
                bad++;
                $display("FAIL busy_start_word%0d: got %h, required %h", 128 + i, mem[128 + i], 32'hC0 + 32'(i));
            end
        end
    endtask

    task automatic test_overlap();
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        expect_copy(32'h0, 32'h4, 3);
        issue(MODE_COPY, 32'h0, 32'h4, 16'd3, 32'h0);
        observe(1);
        total++;
        if (obs_done !== 7) begin
            bad++;
            $display("FAIL overlap_done_cycle: got %0d, required 7", obs_done);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[i] !== 32'd1) begin
                bad++;
                $display("FAIL overlap_word%0d: got %h, required 1", i, mem[i]);
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL overlap_pending: %0d writes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #1;
        test_reset();
        test_copy();
        test_fill();
        test_error();
        test_zero_len_restart();
        test_reset_mid_copy();
        test_start_busy();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
